// File: rtl/spraid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spraid_pkg
//  Description : Shared constants, enums and helpers for the SPI RAID
//                request scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package spraid_pkg;

  localparam int NCH    = 4;
  localparam int LBA_W  = 24;
  localparam int DATA_W = 32;

  typedef enum logic {
    MODE_STRIPE = 1'b0,
    MODE_MIRROR = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Index of the set bit of a one-hot channel mask (0 when empty).
  function automatic logic [1:0] onehot_to_idx(input logic [NCH-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spraid_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : spraid_sched_if
//  Description : Request/response handshake plus broadcast channel command
//                bus between a host and the RAID scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spraid_sched_if;

  logic                                           req_valid;
  logic                                           req_ready;
  logic                                           req_we;
  logic [spraid_pkg::LBA_W-1:0]                   req_lba;
  logic [spraid_pkg::DATA_W-1:0]                  req_wdata;

  logic                                           rsp_valid;
  logic                                           rsp_err;
  logic [spraid_pkg::DATA_W-1:0]                  rsp_rdata;

  logic [spraid_pkg::NCH-1:0]                     ch_start;
  logic                                           ch_we;
  logic [spraid_pkg::LBA_W-1:0]                   ch_addr;
  logic [spraid_pkg::DATA_W-1:0]                  ch_wdata;
  logic [spraid_pkg::NCH-1:0]                     ch_done;
  logic [spraid_pkg::NCH*spraid_pkg::DATA_W-1:0]  ch_rdata;

  // Host / channel-model side
  modport master (
    output req_valid, req_we, req_lba, req_wdata, ch_done, ch_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  ch_start, ch_we, ch_addr, ch_wdata
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_we, req_lba, req_wdata, ch_done, ch_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output ch_start, ch_we, ch_addr, ch_wdata
  );

endinterface
`default_nettype wire

// File: rtl/spraid_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : spraid_rr_pick
//  Description : Combinational round-robin picker. Grants the first usable
//                channel strictly after the last one served, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module spraid_rr_pick
  import spraid_pkg::*;
(
  input  logic [NCH-1:0] usable,
  input  logic [1:0]     last,
  output logic [NCH-1:0] grant,
  output logic           valid
);

  logic [1:0] idx;
  logic       found;

  // Scan last+1 .. last+4 (mod 4); the 2-bit add provides the wrap.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = last + 2'(k);
      if (!found && usable[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid = found;
  end

endmodule
`default_nettype wire

// File: rtl/spraid_sched.sv
`default_nettype none
// ============================================================================
//  Module      : spraid_sched
//  Description : Schedules single-block requests onto four SPI channels in
//                stripe (RAID0) or mirror (RAID1) mode, with completion
//                tracking, timeout and sticky per-channel failure flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module spraid_sched
  import spraid_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           cfg_mode,
  input  logic [NCH-1:0] cfg_chan_en,
  input  logic           fail_clr,
  spraid_sched_if.slave  bus,
  output logic [NCH-1:0] fail_mask
);

  state_e             state;
  logic [NCH-1:0]     target;
  logic [NCH-1:0]     done_seen;
  logic [15:0]        cnt;
  logic [DATA_W-1:0]  rdata;
  logic               we_q;
  logic [1:0]         rr_last;

  logic [NCH-1:0]     usable;
  logic [NCH-1:0]     stripe_oh;
  logic [NCH-1:0]     rr_grant;
  logic               rr_valid;
  logic               is_mirror;
  logic [NCH-1:0]     acc_target;
  logic [NCH-1:0]     done_next;
  logic               hit;
  logic               expired;
  logic [1:0]         tgt_idx;
  logic [DATA_W-1:0]  rd_sel;
  logic [NCH-1:0]     fail_set;

  assign usable    = cfg_chan_en & ~fail_mask;
  assign stripe_oh = 4'b0001 << bus.req_lba[1:0];
  assign is_mirror = (mode_e'(cfg_mode) == MODE_MIRROR);

  spraid_rr_pick u_rr_pick (
    .usable (usable),
    .last   (rr_last),
    .grant  (rr_grant),
    .valid  (rr_valid)
  );

  // Channel set the incoming request would address if accepted now.
  always_comb begin
    acc_target = '0;
    if (!is_mirror)      acc_target = stripe_oh & usable;
    else if (bus.req_we) acc_target = usable;
    else if (rr_valid)   acc_target = rr_grant;
  end

  // Completion in the current cycle counts even if it is also the expiry cycle.
  assign done_next = done_seen | (target & bus.ch_done);
  assign hit       = |(target & bus.ch_done);
  assign expired   = (cnt == 16'(TIMEOUT - 1));
  assign tgt_idx   = onehot_to_idx(target);
  assign rd_sel    = bus.ch_rdata[{tgt_idx, 5'd0} +: DATA_W];
  assign fail_set  = (state == ST_WAIT && done_next != target && expired)
                     ? (target & ~done_next) : '0;

  // Scheduler FSM with registered outputs and sticky failure flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      target        <= '0;
      done_seen     <= '0;
      cnt           <= '0;
      rdata         <= '0;
      we_q          <= 1'b0;
      rr_last       <= 2'd3;
      fail_mask     <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.ch_start  <= '0;
      bus.ch_we     <= 1'b0;
      bus.ch_addr   <= '0;
      bus.ch_wdata  <= '0;
    end else begin
      // A failure recorded in the same cycle as a clear survives it.
      fail_mask <= (fail_clr ? '0 : fail_mask) | fail_set;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            we_q          <= bus.req_we;
            target        <= acc_target;
            done_seen     <= '0;
            rdata         <= '0;
            bus.ch_we     <= bus.req_we;
            bus.ch_wdata  <= bus.req_wdata;
            bus.ch_addr   <= is_mirror ? bus.req_lba : {2'b00, bus.req_lba[LBA_W-1:2]};
            if (is_mirror && !bus.req_we && rr_valid) rr_last <= onehot_to_idx(rr_grant);
            if (acc_target == '0) begin
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state        <= ST_ISSUE;
              bus.ch_start <= acc_target;
            end
          end
        end
        ST_ISSUE: begin
          bus.ch_start <= '0;
          cnt          <= '0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          done_seen <= done_next;
          if (!we_q && hit) rdata <= rd_sel;
          if (done_next == target) begin
            state         <= ST_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= we_q ? '0 : (hit ? rd_sel : rdata);
          end else if (expired) begin
            state         <= ST_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= we_q ? '0 : rdata;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spraid_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spraid_sched
//  Description : Directed self-checking bench for spraid_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spraid_sched;
  import spraid_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_mode;
  logic [3:0] cfg_chan_en;
  logic       fail_clr;
  logic [3:0] fail_mask;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] words [4];

  spraid_sched_if bus ();

  spraid_sched #(.TIMEOUT(TO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cfg_mode    (cfg_mode),
    .cfg_chan_en (cfg_chan_en),
    .fail_clr    (fail_clr),
    .bus         (bus),
    .fail_mask   (fail_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; returns right after the accepting edge.
  task automatic send(input logic mode, input logic [3:0] en, input logic we,
                      input logic [23:0] lba, input logic [31:0] wd);
    cfg_mode      = mode;
    cfg_chan_en   = en;
    bus.req_we    = we;
    bus.req_lba   = lba;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".rspv"},  32'(bus.rsp_valid), 32'd0);
    chk({tag, ".rsperr"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, ".rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, ".start"}, 32'(bus.ch_start), 32'd0);
    chk({tag, ".we"},    32'(bus.ch_we), 32'd0);
    chk({tag, ".addr"},  32'(bus.ch_addr), 32'd0);
    chk({tag, ".wdata"}, bus.ch_wdata, 32'd0);
    chk({tag, ".fmask"}, 32'(fail_mask), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_ch [3];
    logic       seen;
    words[0] = 32'hC0C0_1000;
    words[1] = 32'hC1C1_2001;
    words[2] = 32'hC2C2_3002;
    words[3] = 32'hC3C3_4003;
    exp_ch[0] = 4'h1; exp_ch[1] = 4'h4; exp_ch[2] = 4'h8;

    cfg_mode = 1'b0; cfg_chan_en = 4'hF; fail_clr = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_lba = '0; bus.req_wdata = '0;
    bus.ch_done = '0;
    bus.ch_rdata = {words[3], words[2], words[1], words[0]};

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    chk_reset_outputs("rst");

    // Stripe write lba 7 -> ch3, addr 1, done after 5 cycles
    send(1'b0, 4'hF, 1'b1, 24'h000007, 32'hDEAD_BEEF);
    chk("sw.start", 32'(bus.ch_start), 32'h8);
    chk("sw.addr", 32'(bus.ch_addr), 32'h1);
    chk("sw.we", 32'(bus.ch_we), 32'd1);
    chk("sw.wdata", bus.ch_wdata, 32'hDEAD_BEEF);
    repeat (5) tick();
    chk("sw.start_low", 32'(bus.ch_start), 32'h0);
    chk("sw.addr_hold", 32'(bus.ch_addr), 32'h1);
    chk("sw.no_early", 32'(bus.rsp_valid), 32'd0);
    bus.ch_done = 4'h8; tick(); bus.ch_done = 4'h0;
    chk("sw.rspv", 32'(bus.rsp_valid), 32'd1);
    chk("sw.err", 32'(bus.rsp_err), 32'd0);
    chk("sw.rdata", bus.rsp_rdata, 32'd0);
    tick();
    chk("sw.pulse", 32'(bus.rsp_valid), 32'd0);
    chk("sw.ready", 32'(bus.req_ready), 32'd1);

    // Mirror write en 0xB, done on ch1 (plus stray ch2), ch0, ch3
    send(1'b1, 4'hB, 1'b1, 24'h123456, 32'h0BAD_F00D);
    chk("mw.start", 32'(bus.ch_start), 32'hB);
    chk("mw.addr", 32'(bus.ch_addr), 32'h123456);
    tick();
    bus.ch_done = 4'h6; tick();
    bus.ch_done = 4'h0; tick();
    bus.ch_done = 4'h1; tick();
    bus.ch_done = 4'h0;
    chk("mw.not_yet", 32'(bus.rsp_valid), 32'd0);
    bus.ch_done = 4'h8; tick(); bus.ch_done = 4'h0;
    chk("mw.rspv", 32'(bus.rsp_valid), 32'd1);
    chk("mw.err", 32'(bus.rsp_err), 32'd0);
    tick();

    // Stripe read to ch1 times out; fail_clr pulsed in the expiry cycle
    send(1'b0, 4'hF, 1'b0, 24'h000001, 32'h0);
    chk("to1.start", 32'(bus.ch_start), 32'h2);
    tick();
    repeat (TO - 1) tick();
    chk("to1.no_early", 32'(bus.rsp_valid), 32'd0);
    fail_clr = 1'b1; tick(); fail_clr = 1'b0;
    chk("to1.rspv", 32'(bus.rsp_valid), 32'd1);
    chk("to1.err", 32'(bus.rsp_err), 32'd1);
    chk("to1.fmask", 32'(fail_mask), 32'h2);
    tick();

    // Three mirror reads with ch1 failed: channels 0, 2, 3; min latency
    for (int n = 0; n < 3; n++) begin
      send(1'b1, 4'hF, 1'b0, 24'h000040, 32'h0);
      chk($sformatf("mr%0d.start", n), 32'(bus.ch_start), 32'(exp_ch[n]));
      tick();
      bus.ch_done = exp_ch[n]; tick(); bus.ch_done = 4'h0;
      chk($sformatf("mr%0d.rspv", n), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("mr%0d.err", n), 32'(bus.rsp_err), 32'd0);
      chk($sformatf("mr%0d.rdata", n), bus.rsp_rdata, words[onehot_to_idx(exp_ch[n])]);
      tick();
    end

    // Standalone clear
    fail_clr = 1'b1; tick(); fail_clr = 1'b0;
    chk("clr.fmask", 32'(fail_mask), 32'h0);

    // Stripe read to ch2 times out after 16 WAIT cycles
    send(1'b0, 4'hF, 1'b0, 24'h000002, 32'h0);
    chk("to2.start", 32'(bus.ch_start), 32'h4);
    tick();
    repeat (TO - 1) tick();
    chk("to2.no_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("to2.err", 32'(bus.rsp_err), 32'd1);
    chk("to2.fmask", 32'(fail_mask), 32'h4);
    tick();

    // Request to failed ch2 -> immediate error, no start
    send(1'b0, 4'hF, 1'b0, 24'h000002, 32'h0);
    chk("imm.start", 32'(bus.ch_start), 32'h0);
    chk("imm.rspv", 32'(bus.rsp_valid), 32'd1);
    chk("imm.err", 32'(bus.rsp_err), 32'd1);
    tick();

    // Done lands in the expiry cycle: completion wins
    send(1'b0, 4'hF, 1'b0, 24'h000000, 32'h0);
    tick();
    repeat (TO - 1) tick();
    bus.ch_done = 4'h1; tick(); bus.ch_done = 4'h0;
    chk("exp.rspv", 32'(bus.rsp_valid), 32'd1);
    chk("exp.err", 32'(bus.rsp_err), 32'd0);
    chk("exp.rdata", bus.rsp_rdata, words[0]);
    chk("exp.fmask", 32'(fail_mask), 32'h4);
    tick();

    // Reset while in WAIT: no response, reset values next cycle
    send(1'b0, 4'hF, 1'b1, 24'h000003, 32'h5555_AAAA);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset_outputs("wrst");
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | bus.rsp_valid;
    end
    chk("wrst.no_rsp", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
